core_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle fetch/execute core.
- Separate PC, real memory handshake with wait states, LOAD/STORE, jumps, conditional branch and HALT.
- Connects to a single unified instruction/data memory port through a request/ready handshake.
- Sits between the memory wrapper and the system top; the ALU datapath is inside the block.

---
 rtl/core_mc_if.sv | 23 ++
 rtl/core_mc.sv | 183 ++++++++++++++++++
 tb/tb_core_mc.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mc_if.sv
// core_mc_if: unified instruction/data memory port with a request/ready handshake.
// The core drives the master side; the memory wrapper drives the slave side.
interface core_mc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/core_mc.sv
// core_mc: multi-cycle fetch/execute core (BOOT/FETCH/EXEC/MEM/HALT) on one memory port.
// Define CORE_MC_ZERO_REG_EN to make register 0 a hard-wired zero.
module core_mc #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter int                REG_CNT  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic      clk,
    input  logic      rst,
    core_mc_if.master bus,
    output logic      halted,
    output logic      retire
);
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_MOV, C_LOAD, C_STORE, C_JMP, C_BEQZ, C_HALT
    } cls_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [24:0]       r_instr;
    logic              r_req;
    logic              r_we;
    logic              r_halted;
    logic              r_retire;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_regs [32];

    logic [24:0]       w_fetch;
    cls_t              w_cls;
    logic [6:0]        w_op;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_rd_ok;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_next_pc;

    // Indices at or above REG_CNT read as zero and swallow writes.
    function automatic logic reg_ok(input logic [4:0] idx);
`ifdef CORE_MC_ZERO_REG_EN
        return ({27'd0, idx} < 32'(REG_CNT)) && (idx != 5'd0);
`else
        return {27'd0, idx} < 32'(REG_CNT);
`endif
    endfunction

    if (DATA_W >= 25) begin : g_fetch_wide
        assign w_fetch = bus.mem_rdata[24:0];
    end else begin : g_fetch_narrow
        assign w_fetch = {{(25-DATA_W){1'b0}}, bus.mem_rdata};
    end

    assign w_cls   = cls_t'(r_instr[2:0]);
    assign w_op    = r_instr[9:3];
    assign w_rd    = r_instr[14:10];
    assign w_rs1   = r_instr[19:15];
    assign w_rs2   = r_instr[24:20];
    assign w_a     = reg_ok(w_rs1) ? r_regs[w_rs1] : '0;
    assign w_b     = reg_ok(w_rs2) ? r_regs[w_rs2] : '0;
    assign w_shamt = w_b[SH_W-1:0];
    assign w_rd_ok = reg_ok(w_rd);
    assign w_wr_en = ((w_cls == C_ALU) || (w_cls == C_MOV)) && w_rd_ok;
    assign w_wr_data = (w_cls == C_MOV) ? w_a : w_alu;

    always_comb begin
        w_alu = '0;
        case (w_op)
            7'd0:    w_alu = w_a + w_b;
            7'd1:    w_alu = w_a - w_b;
            7'd2:    w_alu = w_a & w_b;
            7'd3:    w_alu = w_a | w_b;
            7'd4:    w_alu = w_a ^ w_b;
            7'd5:    w_alu = w_a << w_shamt;
            7'd6:    w_alu = w_a >> w_shamt;
            7'd7:    w_alu = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
            default: w_alu = '0;
        endcase
    end

    // r_pc already points past the current instruction once EXEC is reached.
    always_comb begin
        w_next_pc = r_pc;
        if ((w_cls == C_JMP) || ((w_cls == C_BEQZ) && (w_b == '0))) begin
            w_next_pc = w_a[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_halted <= 1'b0;
            r_retire <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_req   <= 1'b1;
                    r_we    <= 1'b0;
                    r_addr  <= r_pc;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_instr <= w_fetch;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_req   <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_cls)
                        C_LOAD, C_STORE: begin
                            r_req   <= 1'b1;
                            r_we    <= (w_cls == C_STORE);
                            r_addr  <= w_a[ADDR_W-1:0];
                            r_wdata <= w_b;
                            r_state <= S_MEM;
                        end
                        C_HALT: begin
                            r_retire <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            if (w_wr_en) begin
                                r_regs[w_rd] <= w_wr_data;
                            end
                            r_retire <= 1'b1;
                            r_pc     <= w_next_pc;
                            r_req    <= 1'b1;
                            r_we     <= 1'b0;
                            r_addr   <= w_next_pc;
                            r_state  <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if ((w_cls == C_LOAD) && w_rd_ok) begin
                            r_regs[w_rd] <= bus.mem_rdata;
                        end
                        r_retire <= 1'b1;
                        r_we     <= 1'b0;
                        r_req    <= 1'b1;
                        r_addr   <= r_pc;
                        r_state  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_req    <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign halted        = r_halted;
    assign retire        = r_retire;
endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: scripted memory responder; expected transfers are queued as programs are built
// and popped/compared as core_mc issues requests.
`timescale 1ns/1ps
module tb_core_mc;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int RC = 16;
    localparam logic [AW-1:0] RPC = 16'h0100;
`ifdef CORE_MC_ZERO_REG_EN
    localparam logic [DW-1:0] ZR = 32'd0;
`else
    localparam logic [DW-1:0] ZR = 32'd9;
`endif
    localparam logic [2:0] NOP = 3'd0, ALU = 3'd1, MOV = 3'd2, LD = 3'd3;
    localparam logic [2:0] ST = 3'd4, JMP = 3'd5, BEQZ = 3'd6, HLT = 3'd7;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          chk_wd;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        int            delta;
        string         nm;
    } xfer_t;

    typedef struct {
        logic [6:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] y;
    } alu_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    logic retire;

    core_mc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    core_mc #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .REG_CNT (RC),
        .RESET_PC(RPC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .halted(halted),
        .retire(retire)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int ret_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (retire === 1'b1) ret_cnt <= ret_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    int last_t = 0;
    int nd = 2;
    int ret_base = 0;
    logic [AW-1:0] pc_m = RPC;
    xfer_t exp_q[$];
    alu_vec_t vt[15];

    function automatic logic [31:0] enc(input logic [2:0] c, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {7'h5A, rs2, rs1, rd, op, c};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    task automatic check_ret(input string nm, input int n);
        check(nm, 64'(ret_cnt - ret_base), 64'(n));
    endtask

    task automatic push_fetch(input logic [31:0] ins, input string nm, input int waits = 0);
        xfer_t x;
        x.we = 1'b0; x.addr = pc_m; x.chk_wd = 1'b0; x.wdata = '0; x.rdata = ins;
        x.waits = waits; x.delta = nd + waits; x.nm = nm;
        exp_q.push_back(x);
        pc_m = pc_m + AW'(1);
        nd = 2;
    endtask

    task automatic push_mem(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] rdata, input string nm, input int waits = 0);
        xfer_t x;
        x.we = we; x.addr = addr; x.chk_wd = we; x.wdata = wdata; x.rdata = rdata;
        x.waits = waits; x.delta = 2 + waits; x.nm = nm;
        exp_q.push_back(x);
        nd = 1;
    endtask

    // Called just after a posedge; each transfer completes on a posedge.
    task automatic serve();
        xfer_t x;
        int n;
        logic [AW+DW:0] snap;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            bus.mem_ready = 1'b0;
            n = 0;
            @(negedge clk);
            while (bus.mem_req !== 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (bus.mem_req !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: mem_req=%b after %0d cycles, want 1", x.nm, bus.mem_req, n);
                exp_q.delete();
                bus.mem_ready = 1'b0;
                return;
            end
            check({x.nm, " we"}, 64'(bus.mem_we), 64'(x.we));
            check({x.nm, " addr"}, 64'(bus.mem_addr), 64'(x.addr));
            if (x.chk_wd) check({x.nm, " wdata"}, 64'(bus.mem_wdata), 64'(x.wdata));
            snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
            for (int i = 0; i < x.waits; i++) begin
                @(negedge clk);
                check({x.nm, " hold"}, 64'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                      64'({1'b1, snap}));
            end
            bus.mem_rdata = x.rdata;
            bus.mem_ready = 1'b1;
            @(posedge clk);
            #1;
            check({x.nm, " lat"}, 64'(cyc - last_t), 64'(x.delta));
            last_t = cyc;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check({nm, " rst ctl"}, 64'({bus.mem_req, bus.mem_we, halted, retire}), 64'(0));
        check({nm, " rst addr"}, 64'(bus.mem_addr), 64'(0));
        check({nm, " rst wdata"}, 64'(bus.mem_wdata), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_t = cyc;
        pc_m = RPC;
        nd = 2;
        ret_base = ret_cnt;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bad;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        vt[0]  = '{7'd0,   32'd5,          32'd7,          32'd12};
        vt[1]  = '{7'd0,   32'hFFFF_FFFF,  32'd1,          32'd0};
        vt[2]  = '{7'd1,   32'd3,          32'd5,          32'hFFFF_FFFE};
        vt[3]  = '{7'd2,   32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200};
        vt[4]  = '{7'd3,   32'hF0F0_1234,  32'h0FF0_FF00,  32'hFFF0_FF34};
        vt[5]  = '{7'd4,   32'hF0F0_1234,  32'h0FF0_FF00,  32'hFF00_ED34};
        vt[6]  = '{7'd5,   32'd1,          32'd31,         32'h8000_0000};
        vt[7]  = '{7'd5,   32'd1,          32'h25,         32'h0000_0020};
        vt[8]  = '{7'd6,   32'h8000_0000,  32'd31,         32'd1};
        vt[9]  = '{7'd6,   32'hF000_0000,  32'd4,          32'h0F00_0000};
        vt[10] = '{7'd7,   32'd3,          32'd5,          32'd1};
        vt[11] = '{7'd7,   32'hFFFF_FFFF,  32'd1,          32'd0};
        vt[12] = '{7'd7,   32'd5,          32'd5,          32'd0};
        vt[13] = '{7'd8,   32'd3,          32'd5,          32'd0};
        vt[14] = '{7'd127, 32'hFFFF,       32'hFFFF,       32'd0};

        // ALU table: load operands, compute into r3, store r3 to [r0]
        do_reset("alu");
        for (int i = 0; i < 15; i++) begin
            push_fetch(enc(LD, 7'd0, 5'd1, 5'd0, 5'd0), "ld a");
            push_mem(1'b0, '0, '0, vt[i].a, "ld a mem");
            push_fetch(enc(LD, 7'd0, 5'd2, 5'd0, 5'd0), "ld b");
            push_mem(1'b0, '0, '0, vt[i].b, "ld b mem");
            push_fetch(enc(ALU, vt[i].op, 5'd3, 5'd1, 5'd2), "alu");
            push_fetch(enc(ST, 7'd0, 5'd0, 5'd0, 5'd3), "st y");
            push_mem(1'b1, '0, vt[i].y, '0, $sformatf("alu%0d op%0d", i, vt[i].op));
        end
        serve();
        repeat (2) @(negedge clk);
        check_ret("alu retire", 60);

        // STORE/LOAD with wait states, register boundaries, branches, pc wrap, HALT
        do_reset("prog");
        push_fetch(enc(LD, 7'd0, 5'd1, 5'd0, 5'd0), "ld r1");
        push_mem(1'b0, 16'h0000, '0, 32'h10, "ld r1 mem");
        push_fetch(enc(LD, 7'd0, 5'd2, 5'd0, 5'd0), "ld r2");
        push_mem(1'b0, 16'h0000, '0, 32'hDEAD_BEEF, "ld r2 mem");
        push_fetch(enc(ST, 7'd0, 5'd0, 5'd1, 5'd2), "st fetch wait4", 4);
        push_mem(1'b1, 16'h0010, 32'hDEAD_BEEF, '0, "st r2");
        push_fetch(enc(LD, 7'd0, 5'd4, 5'd1, 5'd0), "ld r4");
        push_mem(1'b0, 16'h0010, '0, 32'hDEAD_BEEF, "ld r4 mem wait2", 2);
        push_fetch(enc(ST, 7'd0, 5'd0, 5'd0, 5'd4), "st r4");
        push_mem(1'b1, 16'h0000, 32'hDEAD_BEEF, '0, "r4 value");
        push_fetch(enc(LD, 7'd0, 5'd5, 5'd0, 5'd0), "ld r5");
        push_mem(1'b0, 16'h0000, '0, 32'd9, "ld r5 mem");
        push_fetch(enc(MOV, 7'd0, 5'd0, 5'd5, 5'd0), "mov r0");
        push_fetch(enc(ST, 7'd0, 5'd0, 5'd1, 5'd0), "st r0");
        push_mem(1'b1, 16'h0010, ZR, '0, "r0 value");
        push_fetch(enc(LD, 7'd0, 5'd20, 5'd0, 5'd0), "ld r20");
        push_mem(1'b0, AW'(ZR), '0, 32'h55, "ld r20 mem");
        push_fetch(enc(ST, 7'd0, 5'd0, 5'd1, 5'd20), "st r20");
        push_mem(1'b1, 16'h0010, '0, '0, "r20 out of range");
        push_fetch(enc(LD, 7'd0, 5'd6, 5'd1, 5'd0), "ld r6");
        push_mem(1'b0, 16'h0010, '0, 32'h40, "ld r6 mem");
        push_fetch(enc(BEQZ, 7'd0, 5'd0, 5'd6, 5'd7), "beqz zero");
        pc_m = 16'h0040;
        push_fetch(enc(BEQZ, 7'd0, 5'd0, 5'd6, 5'd1), "beqz target");
        push_fetch(enc(LD, 7'd0, 5'd9, 5'd1, 5'd0), "beqz fallthrough");
        push_mem(1'b0, 16'h0010, '0, 32'h0000_FFFF, "ld r9 mem");
        push_fetch(enc(JMP, 7'd0, 5'd0, 5'd9, 5'd0), "jmp");
        pc_m = 16'hFFFF;
        push_fetch(enc(NOP, 7'd0, 5'd0, 5'd0, 5'd0), "jmp target");
        push_fetch(enc(ALU, 7'd0, 5'd8, 5'd1, 5'd5), "pc wrap");
        push_fetch(enc(ST, 7'd0, 5'd0, 5'd0, 5'd8), "st r8");
        push_mem(1'b1, AW'(ZR), 32'h19, '0, "r8 sum");
        push_fetch(enc(HLT, 7'd0, 5'd0, 5'd0, 5'd0), "halt");
        serve();
        repeat (3) @(negedge clk);
        check("halted", 64'(halted), 64'(1));
        check_ret("prog retire", 19);
        n_bad = 0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0 || halted !== 1'b1) n_bad++;
        end
        bus.mem_ready = 1'b0;
        check("halt idle cycles", 64'(n_bad), 64'(0));

        // Reset while a STORE is waiting in MEM: request dropped, never reissued
        do_reset("midmem");
        push_fetch(enc(LD, 7'd0, 5'd1, 5'd0, 5'd0), "ld r1");
        push_mem(1'b0, 16'h0000, '0, 32'h10, "ld r1 mem");
        push_fetch(enc(ST, 7'd0, 5'd0, 5'd1, 5'd2), "st fetch");
        serve();
        @(negedge clk);
        @(negedge clk);
        check("st pending req", 64'({bus.mem_req, bus.mem_we, bus.mem_addr}),
              64'({1'b1, 1'b1, 16'h0010}));
        do_reset("st abort");
        push_fetch(enc(NOP, 7'd0, 5'd0, 5'd0, 5'd0), "refetch at reset pc");
        serve();
        repeat (3) @(negedge clk);
        check_ret("abort retire", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
